// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared states, frame bytes and helpers for the UART command responder
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_DO_WRITE,
        ST_DO_READ,
        ST_READ_WAIT,
        ST_SEND
    } state_t;

    localparam logic [7:0] CMD_W   = 8'h57;
    localparam logic [7:0] CMD_R   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;

    // An address byte is legal only when no bit at or above aw is set.
    function automatic logic addr_in_range(input logic [7:0] b, input int aw);
        if (aw >= 8)
            return 1'b1;
        return ((b >> aw) == 8'd0);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// rtl/uart_cmd_timer.sv - inter-byte idle timer, flags expiry at TIMEOUT-1
module uart_cmd_timer #(
    parameter int TIMEOUT = 100000,
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + 1'b1;
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/uart_cmd_responder.sv
// rtl/uart_cmd_responder.sv - parses W/R register frames from the UART and returns a one-byte response
module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int AW      = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rxdata,
    output logic          read_rx,
    input  logic          tx_empty,
    output logic [7:0]    txdata,
    output logic          write_tx,
    output logic          reg_we,
    output logic          reg_re,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    input  logic [7:0]    reg_rdata,
    output logic          busy,
    output logic [7:0]    err_count
);

    state_t     state;
    logic       guard;
    logic       is_write;
    logic       rd_pending;
    logic [7:0] rsp;
    logic       read_rx_q;
    logic       write_tx_q;
    logic       reg_we_q;
    logic       reg_re_q;
    logic       in_get;
    logic       can_take;
    logic       expired;

    assign in_get   = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    assign can_take = (state == ST_IDLE || in_get) && rx_valid && !guard;

    uart_cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (can_take || !in_get),
        .enable  (in_get),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            guard      <= 1'b0;
            is_write   <= 1'b0;
            rd_pending <= 1'b0;
            rsp        <= 8'h00;
            txdata     <= 8'h00;
            reg_addr   <= '0;
            reg_wdata  <= 8'h00;
            err_count  <= 8'h00;
            read_rx_q  <= 1'b0;
            write_tx_q <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
        end else begin
            read_rx_q  <= can_take;
            guard      <= can_take;
            write_tx_q <= 1'b0;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (can_take) begin
                        if (rxdata == CMD_W || rxdata == CMD_R) begin
                            is_write <= (rxdata == CMD_W);
                            state    <= ST_GET_ADDR;
                        end else begin
                            rsp       <= RSP_ERR;
                            err_count <= sat_inc(err_count);
                            state     <= ST_SEND;
                        end
                    end
                end
                ST_GET_ADDR: begin
                    if (can_take) begin
                        if (!addr_in_range(rxdata, AW)) begin
                            rsp       <= RSP_ERR;
                            err_count <= sat_inc(err_count);
                            state     <= ST_SEND;
                        end else begin
                            reg_addr <= rxdata[AW-1:0];
                            state    <= is_write ? ST_GET_DATA : ST_DO_READ;
                        end
                    end else if (expired) begin
                        err_count <= sat_inc(err_count);
                        state     <= ST_IDLE;
                    end
                end
                ST_GET_DATA: begin
                    if (can_take) begin
                        reg_wdata <= rxdata;
                        state     <= ST_DO_WRITE;
                    end else if (expired) begin
                        err_count <= sat_inc(err_count);
                        state     <= ST_IDLE;
                    end
                end
                ST_DO_WRITE: begin
                    reg_we_q <= 1'b1;
                    rsp      <= RSP_OK;
                    state    <= ST_SEND;
                end
                ST_DO_READ: begin
                    reg_re_q <= 1'b1;
                    state    <= ST_READ_WAIT;
                end
                ST_READ_WAIT: begin
                    rd_pending <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    // Read data is only valid on the first SEND cycle; hold it in rsp across a tx stall.
                    if (rd_pending) begin
                        rsp        <= reg_rdata;
                        rd_pending <= 1'b0;
                    end
                    if (tx_empty) begin
                        txdata     <= rd_pending ? reg_rdata : rsp;
                        write_tx_q <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are masked while rst is high so nothing fires in the reset cycle itself.
    assign read_rx  = read_rx_q  & ~rst;
    assign write_tx = write_tx_q & ~rst;
    assign reg_we   = reg_we_q   & ~rst;
    assign reg_re   = reg_re_q   & ~rst;
    assign busy     = (state != ST_IDLE);

endmodule
